// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM states, STAT bit positions, default register addresses.
package mmio_uart_tx_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] UART_ADDR_DATA = 11'h7F0;
    localparam logic [ADDR_W-1:0] UART_ADDR_STAT = 11'h7F4;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 8;
    localparam int STAT_CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    function automatic logic [DATA_W-1:0] pack_stat(
        input logic                  empty,
        input logic                  full,
        input logic                  busy,
        input logic                  ovf,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [DATA_W-1:0] s;
        s = '0;
        s[STAT_EMPTY] = empty;
        s[STAT_FULL]  = full;
        s[STAT_BUSY]  = busy;
        s[STAT_OVF]   = ovf;
        s[STAT_CNT +: STAT_CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory-side bus seen by the UART: CPU is master, UART is slave.
interface mmio_uart_tx_if;
    import mmio_uart_tx_pkg::*;

    logic              io_w;
    logic              io_r;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_sel;

    modport master (
        output io_w, io_r, io_addr, io_wdata,
        input  io_rdata, io_sel
    );

    modport slave (
        input  io_w, io_r, io_addr, io_wdata,
        output io_rdata, io_sel
    );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count; accepts a push when full
// only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PTR_W'(1);
        if (do_pop)  rd_d = rd_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and status register.
// Define UART_PARITY_EN to append an even parity bit (8E1).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int                CLKS_PER_BIT = 868,
    parameter int                FIFO_DEPTH   = 16,
    parameter logic [ADDR_W-1:0] ADDR_DATA    = UART_ADDR_DATA,
    parameter logic [ADDR_W-1:0] ADDR_STAT    = UART_ADDR_STAT
) (
    input  logic           clk,
    input  logic           rstn,
    mmio_uart_tx_if.slave  bus,
    output logic           txd
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              ovf_q, ovf_d;
`ifdef UART_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              push_req;
    logic              clr_req;
    logic              ovf_evt;
    logic              pop;
    logic              baud_done;
    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [DATA_W-1:0] stat;
    logic              unused_wdata;

    assign push_req  = bus.io_w && (bus.io_addr == ADDR_DATA);
    assign clr_req   = bus.io_w && (bus.io_addr == ADDR_STAT) && bus.io_wdata[0];
    assign ovf_evt   = push_req && fifo_full && !pop;
    assign baud_done = (baud_q == BAUD_LAST);
    assign unused_wdata = ^bus.io_wdata[DATA_W-1:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_req),
        .wdata (bus.io_wdata[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign stat = pack_stat(fifo_empty, fifo_full, state_q != S_IDLE,
                            ovf_q, STAT_CNT_W'(fifo_count));
    assign bus.io_sel   = (bus.io_addr == ADDR_DATA) || (bus.io_addr == ADDR_STAT);
    assign bus.io_rdata = (bus.io_r && bus.io_addr == ADDR_STAT) ? stat : '0;
    assign txd = txd_q;

    // A same-cycle overflow beats a software clear.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_req) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
`ifdef UART_PARITY_EN
                    par_d   = ^fifo_rdata;
`endif
                    state_d = S_START;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (!baud_done) begin
                    baud_d = baud_q + CNT_W'(1);
                end else if (bit_q == 3'd7) begin
                    baud_d = '0;
`ifdef UART_PARITY_EN
                    state_d = S_PARITY;
                    txd_d   = par_q;
`else
                    state_d = S_STOP;
                    txd_d   = 1'b1;
`endif
                end else begin
                    baud_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    txd_d   = shift_q[1];
                end
            end
            S_PARITY: begin
                if (baud_done) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed frames plus random bus traffic
// checked against a byte-queue / bit-stream reference model.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic txd;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq [$];
    logic       mline [$];
    logic       m_txd  = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_stat();
        return {19'd0, 5'(mq.size()), 4'd0, m_ovf, m_busy,
                mq.size() == DEPTH, mq.size() == 0};
    endfunction

    task automatic model_reset();
        mq.delete();
        mline.delete();
        m_txd  = 1'b1;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Whole frame as a per-cycle line level, LSB first.
    task automatic load_frame(input logic [7:0] b);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int j = 0; j < CPB; j++) mline.push_back(bits[i]);
    endtask

    task automatic model_edge(input logic w, input logic [10:0] a,
                              input logic [31:0] d);
        if (mline.size() > 0) begin
            m_txd  = mline.pop_front();
            m_busy = 1'b1;
        end else if (m_busy) begin
            m_txd  = 1'b1;
            m_busy = 1'b0;
        end else if (mq.size() > 0) begin
            load_frame(mq.pop_front());
            m_txd  = mline.pop_front();
            m_busy = 1'b1;
        end else begin
            m_txd = 1'b1;
        end
        if (w && a == UART_ADDR_STAT && d[0]) m_ovf = 1'b0;
        if (w && a == UART_ADDR_DATA) begin
            if (mq.size() < DEPTH) mq.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic read_stat(output logic [31:0] v);
        bus.io_w    = 1'b0;
        bus.io_r    = 1'b1;
        bus.io_addr = UART_ADDR_STAT;
        #1;
        v = bus.io_rdata;
        bus.io_r = 1'b0;
    endtask

    task automatic tick(input logic w, input logic [10:0] a,
                        input logic [31:0] d);
        logic [31:0] s;
        bus.io_w     = w;
        bus.io_r     = 1'b0;
        bus.io_addr  = a;
        bus.io_wdata = d;
        @(posedge clk);
        if (!rstn) model_reset();
        else model_edge(w, a, d);
        @(negedge clk);
        chk("txd", 32'(txd), 32'(m_txd));
        read_stat(s);
        chk("stat", s, m_stat());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 11'h000, 32'h0);
    endtask

    // bits listed first-to-last in the MSB-first vector.
    task automatic send_expect(input logic [7:0] b, input logic [10:0] bits);
        logic [31:0] s;
        tick(1'b1, UART_ADDR_DATA, {24'h0, b});
        for (int i = 0; i < FB; i++)
            for (int j = 0; j < CPB; j++) begin
                tick(1'b0, 11'h000, 32'h0);
                chk("frame_bit", 32'(txd), 32'(bits[FB-1-i]));
                read_stat(s);
                chk("busy_in_frame", 32'(s[2]), 32'h1);
            end
        tick(1'b0, 11'h000, 32'h0);
        read_stat(s);
        chk("busy_after_frame", 32'(s[2]), 32'h0);
    endtask

    initial begin
        logic [31:0] s;
        int r;
        bus.io_w     = 1'b0;
        bus.io_r     = 1'b0;
        bus.io_addr  = '0;
        bus.io_wdata = '0;

        rstn = 1'b0;
        idle(3);
        read_stat(s);
        chk("reset_stat", s, 32'h0000_0001);
        chk("reset_txd", 32'(txd), 32'h1);
        rstn = 1'b1;

        bus.io_addr = UART_ADDR_STAT;
        #1;
        chk("rdata_no_r", bus.io_rdata, 32'h0);
        chk("sel_stat", 32'(bus.io_sel), 32'h1);
        bus.io_r    = 1'b1;
        bus.io_addr = UART_ADDR_DATA;
        #1;
        chk("rdata_data_addr", bus.io_rdata, 32'h0);
        chk("sel_data", 32'(bus.io_sel), 32'h1);
        bus.io_addr = 11'h100;
        #1;
        chk("sel_other", 32'(bus.io_sel), 32'h0);
        bus.io_r = 1'b0;
        idle(2);

`ifdef UART_PARITY_EN
        send_expect(8'hA5, 11'b01010010101);
        send_expect(8'h07, 11'b01110000011);
        send_expect(8'h03, 11'b01100000001);
`else
        send_expect(8'hA5, 11'b00101001011);
        send_expect(8'h07, 11'b00111000001);
        send_expect(8'h03, 11'b00110000001);
`endif

        tick(1'b1, UART_ADDR_DATA, 32'h00);
        tick(1'b1, UART_ADDR_DATA, 32'hFF);
        idle(2 * FB * CPB + 5);

        for (int i = 0; i < 6; i++)
            tick(1'b1, UART_ADDR_DATA, 32'($urandom_range(0, 255)));
        read_stat(s);
        chk("ovf_flag", 32'(s[3]), 32'h1);
        chk("ovf_count", 32'(s[12:8]), 32'h4);
        tick(1'b1, UART_ADDR_STAT, 32'h1);
        read_stat(s);
        chk("ovf_clear", 32'(s[3]), 32'h0);
        idle(5 * (FB * CPB + 1) + 5);

        for (int i = 0; i < 3; i++)
            tick(1'b1, UART_ADDR_DATA, 32'($urandom_range(0, 255)));
        idle(15);
        rstn = 1'b0;
        tick(1'b0, 11'h000, 32'h0);
        chk("midreset_txd", 32'(txd), 32'h1);
        read_stat(s);
        chk("midreset_stat", s, 32'h0000_0001);
        rstn = 1'b1;
        idle(60);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4)
                tick(1'b1, UART_ADDR_DATA, $urandom);
            else if (r < 6)
                tick(1'b1, UART_ADDR_STAT, $urandom);
            else if (r < 7)
                tick(1'b0, UART_ADDR_STAT, $urandom);
            else
                tick(1'b0, 11'($urandom), $urandom);
        end
        idle((DEPTH + 1) * (FB * CPB + 1) + 5);
        read_stat(s);
        chk("final_empty", 32'(s[0]), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
